// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// registered overflow/underflow pulses and optional first-word-fall-through output.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              wr_acc;
  logic              rd_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign count        = count_q;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & ~wr_acc;
      underflow <= rd_en & ~rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem[rd_ptr];
      end
    end

    assign data_out = dout_q;
  end

endmodule
